// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture FIFO for the KS10 CPU: samples {PC,HR} on register-update strobes.
// Optional macro CPU_TRACE_TIMESTAMP_EN prepends a saturating 16-bit cycle timestamp to each entry.
module cpu_trace_buffer #(
    parameter int PC_WIDTH   = 18,
    parameter int HR_WIDTH   = 36,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PC_WIDTH-1:0]     cpuPC,
    input  logic [HR_WIDTH-1:0]     cpuHR,
    input  logic                    regsLOAD,
    input  logic                    cpuRUN,
    input  logic                    trARM,
    input  logic                    trCLR,
    input  logic                    trMODE,
    input  logic [PC_WIDTH-1:0]     trTRIGPC,
    input  logic [DEPTH_LOG2:0]     trPOST,
    input  logic                    trRDREQ,
`ifdef CPU_TRACE_TIMESTAMP_EN
    output logic [16+PC_WIDTH+HR_WIDTH-1:0] trDATA,
`else
    output logic [PC_WIDTH+HR_WIDTH-1:0]    trDATA,
`endif
    output logic                    trVALID,
    output logic                    trEMPTY,
    output logic                    trFULL,
    output logic                    trDONE,
    output logic [DEPTH_LOG2:0]     trCOUNT
);

`ifdef CPU_TRACE_TIMESTAMP_EN
    localparam int DW = 16 + PC_WIDTH + HR_WIDTH;
`else
    localparam int DW = PC_WIDTH + HR_WIDTH;
`endif
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0]         LAST_CNT   = CW'(DEPTH - 1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t                r_state;
    logic [DW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_post;
    logic [DW-1:0]         r_data;
    logic                  r_valid;

    logic          w_capturing;
    logic          w_wr;
    logic          w_rd;
    logic          w_full;
    logic          w_trig;
    logic [DW-1:0] w_entry;

    assign w_capturing = (r_state == ARMED) || (r_state == POST);
    assign w_full      = (r_count == FULL_CNT);
    // Control pulses pre-empt any data movement in the same cycle.
    assign w_wr   = regsLOAD && cpuRUN && w_capturing && !trCLR && !trARM;
    assign w_rd   = trRDREQ && ((r_state == IDLE) || (r_state == DONE)) &&
                    (r_count != '0) && !trCLR && !trARM;
    assign w_trig = (r_state == ARMED) && (cpuPC == trTRIGPC);

`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else if (trARM) begin
            r_ts <= '0;
        end else if (w_capturing && (r_ts != 16'hFFFF)) begin
            r_ts <= r_ts + 16'd1;
        end
    end

    assign w_entry = {r_ts, cpuPC, cpuHR};
`else
    assign w_entry = {cpuPC, cpuHR};
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Capture FSM, pointers, occupancy counter and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_post  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) begin
                r_data <= r_mem[r_rptr];
            end

            if (trCLR || trARM) begin
                r_state <= trCLR ? IDLE : ARMED;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_post  <= '0;
            end else if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
                if (!trMODE && (r_state == ARMED)) begin
                    r_count <= r_count + CNT_ONE;
                    if (r_count == LAST_CNT) begin
                        r_state <= DONE;
                    end
                end else begin
                    // Circular capture: once full, each new entry evicts the oldest.
                    if (w_full) begin
                        r_rptr <= r_rptr + PTR_ONE;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                    if (w_trig) begin
                        r_post  <= trPOST;
                        r_state <= (trPOST == '0) ? DONE : POST;
                    end else if (r_state == POST) begin
                        r_post <= r_post - CNT_ONE;
                        if (r_post == CNT_ONE) begin
                            r_state <= DONE;
                        end
                    end
                end
            end else if (w_rd) begin
                r_rptr  <= r_rptr + PTR_ONE;
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign trDATA  = r_data;
    assign trVALID = r_valid;
    assign trEMPTY = (r_count == '0);
    assign trFULL  = w_full;
    assign trDONE  = (r_state == DONE);
    assign trCOUNT = r_count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer (DEPTH_LOG2=3); timestamp checks when CPU_TRACE_TIMESTAMP_EN is defined.
module tb_cpu_trace_buffer;

    localparam int PW    = 18;
    localparam int HW    = 36;
    localparam int DL    = 3;
    localparam int DEPTH = 8;
    localparam int EW    = PW + HW;
`ifdef CPU_TRACE_TIMESTAMP_EN
    localparam int DW = 16 + EW;
`else
    localparam int DW = EW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] cpuPC = '0;
    logic [HW-1:0] cpuHR = '0;
    logic          regsLOAD = 1'b0;
    logic          cpuRUN = 1'b0;
    logic          trARM = 1'b0;
    logic          trCLR = 1'b0;
    logic          trMODE = 1'b0;
    logic [PW-1:0] trTRIGPC = '0;
    logic [DL:0]   trPOST = '0;
    logic          trRDREQ = 1'b0;
    logic [DW-1:0] trDATA;
    logic          trVALID;
    logic          trEMPTY;
    logic          trFULL;
    logic          trDONE;
    logic [DL:0]   trCOUNT;

    int nChecks = 0;
    int nFails  = 0;
    logic [EW-1:0] expQ [$];

    cpu_trace_buffer #(.PC_WIDTH(PW), .HR_WIDTH(HW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .cpuPC(cpuPC), .cpuHR(cpuHR), .regsLOAD(regsLOAD),
        .cpuRUN(cpuRUN), .trARM(trARM), .trCLR(trCLR), .trMODE(trMODE),
        .trTRIGPC(trTRIGPC), .trPOST(trPOST), .trRDREQ(trRDREQ), .trDATA(trDATA),
        .trVALID(trVALID), .trEMPTY(trEMPTY), .trFULL(trFULL), .trDONE(trDONE),
        .trCOUNT(trCOUNT)
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] mkHR(input logic [PW-1:0] pc);
        return {18'h2B3C4, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic run, input logic [PW-1:0] pc);
        regsLOAD = load;
        cpuRUN   = run;
        cpuPC    = pc;
        cpuHR    = mkHR(pc);
        tick();
        regsLOAD = 1'b0;
    endtask

    task automatic pulseArm(input logic mode, input logic [PW-1:0] trig, input logic [DL:0] post);
        trMODE   = mode;
        trTRIGPC = trig;
        trPOST   = post;
        trARM    = 1'b1;
        tick();
        trARM    = 1'b0;
        expQ.delete();
    endtask

    // Back-to-back pops; each result is checked one cycle after its request.
    task automatic readEntries(input int n);
        logic [EW-1:0] exp;
        trRDREQ = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            checkOutput("rdValid", trVALID, 1);
            checkOutput("rdData", trDATA[EW-1:0], exp);
        end
        trRDREQ = 1'b0;
        tick();
        checkOutput("rdValidDrop", trVALID, 0);
    endtask

    task automatic runMode1(input logic [PW-1:0] trig, input logic [DL:0] post,
                            input logic [PW-1:0] base, input int n);
        bit expDone = 0;
        bit trigSeen = 0;
        int remain = 0;
        logic [PW-1:0] pc;
        pulseArm(1'b1, trig, post);
        for (int i = 0; i < n; i++) begin
            pc = base + PW'(i);
            applyStimulus(1'b1, 1'b1, pc);
            if (!expDone) begin
                expQ.push_back({pc, mkHR(pc)});
                if (expQ.size() > DEPTH) void'(expQ.pop_front());
                if (trigSeen) begin
                    remain--;
                    if (remain == 0) expDone = 1;
                end else if (pc == trig) begin
                    trigSeen = 1;
                    remain = int'(post);
                    if (post == 0) expDone = 1;
                end
            end
            checkOutput("m1Done", trDONE, expDone);
        end
        checkOutput("m1Count", trCOUNT, expQ.size());
    endtask

`ifdef CPU_TRACE_TIMESTAMP_EN
    task automatic runTimestamp(input int idle, input logic [15:0] expTs);
        pulseArm(1'b1, 18'd500, '0);
        for (int i = 0; i < idle; i++) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b1, 18'd500);
        checkOutput("tsDone", trDONE, 1);
        trRDREQ = 1'b1;
        tick();
        trRDREQ = 1'b0;
        checkOutput("tsValid", trVALID, 1);
        checkOutput("tsValue", trDATA[DW-1 -: 16], expTs);
        checkOutput("tsPC", trDATA[EW-1 -: PW], 500);
    endtask
`endif

    initial begin
        tick();
        tick();
        checkOutput("rstCount", trCOUNT, 0);
        checkOutput("rstEmpty", trEMPTY, 1);
        checkOutput("rstFull", trFULL, 0);
        checkOutput("rstDone", trDONE, 0);
        checkOutput("rstValid", trVALID, 0);
        checkOutput("rstData", trDATA, 0);
        rst = 1'b0;

        // Stop-when-full capture of ten strobes keeps only the first eight.
        pulseArm(1'b0, '0, '0);
        checkOutput("armCount", trCOUNT, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, PW'(100 + i));
            if (i < DEPTH) expQ.push_back({PW'(100 + i), mkHR(PW'(100 + i))});
            checkOutput("m0Count", trCOUNT, (i < DEPTH) ? i + 1 : DEPTH);
            checkOutput("m0Done", trDONE, (i >= DEPTH - 1) ? 1 : 0);
        end
        checkOutput("m0Full", trFULL, 1);
        readEntries(8);
        checkOutput("m0Empty", trEMPTY, 1);
        checkOutput("m0CountEnd", trCOUNT, 0);
        trRDREQ = 1'b1;
        tick();
        trRDREQ = 1'b0;
        checkOutput("rdEmptyIgnored", trVALID, 0);

        // Circular capture with trigger mid-stream, then with overwrite of old entries.
        runMode1(18'd205, 4'd2, 18'd200, 16);
        readEntries(8);
        runMode1(18'd205, 4'd4, 18'd200, 16);
        readEntries(8);

        // Trigger on the very first write with no post-trigger entries.
        runMode1(18'd300, 4'd0, 18'd300, 4);
        readEntries(1);
        checkOutput("trigFirstEmpty", trEMPTY, 1);

        // Paused CPU and reads while armed must not disturb the buffer.
        pulseArm(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, PW'(600 + i));
        checkOutput("pauseCount", trCOUNT, 0);
        applyStimulus(1'b1, 1'b1, 18'd610);
        applyStimulus(1'b1, 1'b1, 18'd611);
        checkOutput("runCount", trCOUNT, 2);
        trRDREQ = 1'b1;
        tick();
        trRDREQ = 1'b0;
        checkOutput("armedRdValid", trVALID, 0);
        checkOutput("armedRdCount", trCOUNT, 2);

        // Clear beats arm and load in the same cycle; buffer then idles.
        trCLR = 1'b1;
        trARM = 1'b1;
        applyStimulus(1'b1, 1'b1, 18'd700);
        trCLR = 1'b0;
        trARM = 1'b0;
        checkOutput("clrCount", trCOUNT, 0);
        checkOutput("clrEmpty", trEMPTY, 1);
        checkOutput("clrDone", trDONE, 0);
        applyStimulus(1'b1, 1'b1, 18'd701);
        checkOutput("idleNoCapture", trCOUNT, 0);

        // Synchronous reset while in post-trigger capture.
        pulseArm(1'b1, 18'd400, 4'd5);
        applyStimulus(1'b1, 1'b1, 18'd400);
        applyStimulus(1'b1, 1'b1, 18'd401);
        checkOutput("postCount", trCOUNT, 2);
        checkOutput("postNotDone", trDONE, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRstCount", trCOUNT, 0);
        checkOutput("midRstEmpty", trEMPTY, 1);
        checkOutput("midRstFull", trFULL, 0);
        checkOutput("midRstDone", trDONE, 0);
        checkOutput("midRstValid", trVALID, 0);
        checkOutput("midRstData", trDATA, 0);

`ifdef CPU_TRACE_TIMESTAMP_EN
        runTimestamp(3, 16'd3);
        runTimestamp(70000, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
